rdc_ctrl: RTL and testbench
===========================

Name: rdc_ctrl

Overview:
- Sequencing controller for the request duration counter (RDC): arms it, applies software weights atomically, bounds monitoring to programmable windows, and captures the offending-event vector when RDC interrupts.
- Raises a core interrupt and holds it until acknowledged, then clears and re-arms RDC.
- Sits between the SafeSU register interface and the RDC instance; it drives the RDC enable and weights inputs.

Parameters:
N_CORES, 4, monitored cores
CORE_EVENTS, 2, events per core
WEIGHTS_WIDTH, 8, weight / counter width
WINDOW_WIDTH, 32, window length counter width
N_EV (localparam), N_CORES*CORE_EVENTS, total monitored events; IDX_W = $clog2(N_EV)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
start_i  in  1  arm request (level sampled per cycle)
stop_i  in  1  disarm request, highest priority
window_i  in  WINDOW_WIDTH  window length in cycles; 0 = unbounded
weight_wr_i  in  1  shadow weight write strobe
weight_idx_i  in  IDX_W  event index (core*CORE_EVENTS+event)
weight_data_i  in  WEIGHTS_WIDTH  shadow weight value
rdc_irq_i  in  1  RDC interrupt (combinational, sticky while enabled)
rdc_vector_i  in  N_EV  RDC registered interrupt vector, flattened, bit core*CORE_EVENTS+event
irq_ack_i  in  1  software acknowledge
rdc_enable_o  out  1  RDC enable
weights_o  out  N_EV*WEIGHTS_WIDTH  active weights, event i at [i*W +: W]
irq_o  out  1  core interrupt
captured_vector_o  out  N_EV  offending events of the last interrupt
irq_count_o  out  8  saturating interrupt count
window_done_o  out  1  one-cycle pulse per completed window
state_o  out  3  FSM state

Behaviour:
- Reset, clock: reset rstn_i, asynchronous, active-low; clock clk_i. All state is asynchronously reset.
- Reset values:
  - state IDLE.
  - shadow and active weights all-ones (least sensitive).
  - captured_vector_o 0, irq_count_o 0, window_done_o 0, window counter 0.
- FSM states: IDLE=0, CLEAR=1, ARMED=2, CAPTURE=3, HOLD=4.
- Decoded outputs: rdc_enable_o = (ARMED or CAPTURE); irq_o = HOLD.
- IDLE: start_i && !stop_i -> CLEAR.
- CLEAR (exactly 1 cycle, RDC disabled so its counters and vector clear):
  - active weights <= shadow weights.
  - window counter <= window_i.
  - -> ARMED; stop_i -> IDLE.
- ARMED. Priority: stop_i > rdc_irq_i > window expiry.
  - stop_i -> IDLE.
  - rdc_irq_i -> CAPTURE; irq_count_o += 1, saturating at 255.
  - Else, if window counter != 0: decrement. When the counter is 1, go to CLEAR and pulse window_done_o high during that CLEAR cycle (registered).
  - ARMED lasts exactly window_i cycles when no interrupt occurs.
- CAPTURE (1 cycle, RDC still enabled, lets the registered RDC vector catch up):
  - captured_vector_o <= rdc_vector_i.
  - -> HOLD; stop_i -> IDLE without capture.
  - Window expiry is ignored.
- HOLD (RDC disabled; its watermarks are frozen):
  - irq_ack_i -> CLEAR (auto re-arm, fresh window).
  - stop_i -> IDLE; stop wins over a simultaneous ack.
  - captured_vector_o is held until the next CAPTURE.
- start_i is ignored outside IDLE.
- Weight writes:
  - Write shadow[weight_idx_i] in any state; active weights change only in CLEAR.
  - A write in the same cycle as CLEAR updates shadow only; active takes the pre-write shadow value.
  - Out-of-range index: write dropped.
- Reset mid-operation: immediate return to IDLE with reset values; no pulse or irq is emitted.

Test Plan:
- Reset, start_i=1 for 1 cycle, window_i=0 -> state 0,1,2; rdc_enable_o=0 during CLEAR and 1 from ARMED on; weights_o all 0xFF.
- Write idx 3=0x05, start, window_i=10, no irq -> ARMED for exactly 10 cycles, then CLEAR with window_done_o=1 for 1 cycle, then ARMED again; weights_o[3]=0x05 from the first CLEAR.
- In ARMED, rdc_irq_i=1 and one cycle later rdc_vector_i=0x08 -> CAPTURE then HOLD; irq_o=1, captured_vector_o=0x08, irq_count_o=1, rdc_enable_o=0. irq_ack_i -> CLEAR -> ARMED; irq_o=0.
- rdc_irq_i in the same cycle the window counter is 1 -> CAPTURE taken, no window_done_o pulse. stop_i with irq_ack_i in HOLD -> IDLE, irq_o=0.
- 256 interrupt/ack cycles -> irq_count_o saturates at 255. weight_wr_i in the CLEAR cycle with 0x01 (shadow previously 0x05) -> active 0x05 now, 0x01 after the next CLEAR.
- rstn_i low in HOLD -> all outputs at reset values within the same cycle (asynchronous); state_o=0.

Source files
------------

// File: rtl/rdc_ctrl_if.sv
// Bus between the SafeSU register side and the RDC sequencing controller.
// The master modport is the software/RDC side, the slave modport is rdc_ctrl.
interface rdc_ctrl_if #(
  parameter int N_CORES       = 4,
  parameter int CORE_EVENTS   = 2,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int WINDOW_WIDTH  = 32
);
  localparam int N_EV  = N_CORES * CORE_EVENTS;
  localparam int IDX_W = (N_EV > 1) ? $clog2(N_EV) : 1;

  logic                          start_i;
  logic                          stop_i;
  logic [WINDOW_WIDTH-1:0]       window_i;
  logic                          weight_wr_i;
  logic [IDX_W-1:0]              weight_idx_i;
  logic [WEIGHTS_WIDTH-1:0]      weight_data_i;
  logic                          rdc_irq_i;
  logic [N_EV-1:0]               rdc_vector_i;
  logic                          irq_ack_i;
  logic                          rdc_enable_o;
  logic [N_EV*WEIGHTS_WIDTH-1:0] weights_o;
  logic                          irq_o;
  logic [N_EV-1:0]               captured_vector_o;
  logic [7:0]                    irq_count_o;
  logic                          window_done_o;
  logic [2:0]                    state_o;

  modport master (
    output start_i, stop_i, window_i, weight_wr_i, weight_idx_i, weight_data_i,
           rdc_irq_i, rdc_vector_i, irq_ack_i,
    input  rdc_enable_o, weights_o, irq_o, captured_vector_o, irq_count_o,
           window_done_o, state_o
  );

  modport slave (
    input  start_i, stop_i, window_i, weight_wr_i, weight_idx_i, weight_data_i,
           rdc_irq_i, rdc_vector_i, irq_ack_i,
    output rdc_enable_o, weights_o, irq_o, captured_vector_o, irq_count_o,
           window_done_o, state_o
  );
endinterface

// File: rtl/rdc_ctrl.sv
// Sequencing controller for the request duration counter: arming, atomic weight
// updates, bounded monitoring windows and interrupt capture/acknowledge.
module rdc_ctrl #(
  parameter int N_CORES       = 4,
  parameter int CORE_EVENTS   = 2,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int WINDOW_WIDTH  = 32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  rdc_ctrl_if.slave    bus
);
  localparam int N_EV = N_CORES * CORE_EVENTS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ARMED   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [WEIGHTS_WIDTH-1:0]  shadow_q [N_EV];
  logic [WEIGHTS_WIDTH-1:0]  shadow_d [N_EV];
  logic [WEIGHTS_WIDTH-1:0]  active_q [N_EV];
  logic [WEIGHTS_WIDTH-1:0]  active_d [N_EV];
  logic [WINDOW_WIDTH-1:0]   win_cnt_q, win_cnt_d;
  logic [N_EV-1:0]           captured_q, captured_d;
  logic [7:0]                irq_count_q, irq_count_d;
  logic                      window_done_q, window_done_d;
  logic [N_EV*WEIGHTS_WIDTH-1:0] weights_flat;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      captured_q    <= '0;
      irq_count_q   <= '0;
      window_done_q <= 1'b0;
      for (int i = 0; i < N_EV; i++) begin
        shadow_q[i] <= '1;
        active_q[i] <= '1;
      end
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      captured_q    <= captured_d;
      irq_count_q   <= irq_count_d;
      window_done_q <= window_done_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  // Shadow writes are accepted in every state; CLEAR copies the pre-write shadow.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.weight_wr_i && (int'(bus.weight_idx_i) < N_EV)) begin
      shadow_d[bus.weight_idx_i] = bus.weight_data_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    active_d      = active_q;
    captured_d    = captured_q;
    irq_count_d   = irq_count_q;
    window_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.stop_i) state_d = CLEAR;
      end
      CLEAR: begin
        active_d  = shadow_q;
        win_cnt_d = bus.window_i;
        state_d   = bus.stop_i ? IDLE : ARMED;
      end
      ARMED: begin
        if (bus.stop_i) begin
          state_d = IDLE;
        end else if (bus.rdc_irq_i) begin
          state_d = CAPTURE;
          if (irq_count_q != 8'hFF) irq_count_d = irq_count_q + 8'd1;
        end else if (win_cnt_q != '0) begin
          win_cnt_d = win_cnt_q - 1'b1;
          if (win_cnt_q == WINDOW_WIDTH'(1)) begin
            state_d       = CLEAR;
            window_done_d = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (bus.stop_i) begin
          state_d = IDLE;
        end else begin
          captured_d = bus.rdc_vector_i;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.stop_i) state_d = IDLE;
        else if (bus.irq_ack_i) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_EV; gi++) begin : g_weights
      assign weights_flat[gi*WEIGHTS_WIDTH +: WEIGHTS_WIDTH] = active_q[gi];
    end
  endgenerate

  always_comb begin
    bus.rdc_enable_o      = (state_q == ARMED) || (state_q == CAPTURE);
    bus.irq_o             = (state_q == HOLD);
    bus.state_o           = state_q;
    bus.weights_o         = weights_flat;
    bus.captured_vector_o = captured_q;
    bus.irq_count_o       = irq_count_q;
    bus.window_done_o     = window_done_q;
  end
endmodule

// File: tb/tb_rdc_ctrl.sv
// Directed self-checking bench for rdc_ctrl with hand-computed expectations.
module tb_rdc_ctrl;
  logic clk_i = 1'b0;
  logic rstn_i;
  int   checks = 0;
  int   failures = 0;

  rdc_ctrl_if #(.N_CORES(4), .CORE_EVENTS(2), .WEIGHTS_WIDTH(8), .WINDOW_WIDTH(32)) bus ();

  rdc_ctrl #(.N_CORES(4), .CORE_EVENTS(2), .WEIGHTS_WIDTH(8), .WINDOW_WIDTH(32)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rstn_i            = 1'b0;
    bus.start_i       = 1'b0;
    bus.stop_i        = 1'b0;
    bus.window_i      = '0;
    bus.weight_wr_i   = 1'b0;
    bus.weight_idx_i  = '0;
    bus.weight_data_i = '0;
    bus.rdc_irq_i     = 1'b0;
    bus.rdc_vector_i  = '0;
    bus.irq_ack_i     = 1'b0;
    tick();
    tick();
    chk("rst_state", 64'(bus.state_o), 64'd0);
    chk("rst_weights", bus.weights_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_capt", 64'(bus.captured_vector_o), 64'd0);
    chk("rst_count", 64'(bus.irq_count_o), 64'd0);
    chk("rst_wdone", 64'(bus.window_done_o), 64'd0);
    chk("rst_en", 64'(bus.rdc_enable_o), 64'd0);
    rstn_i = 1'b1;
    tick();

    // Unbounded window arm sequence
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("t1_clear_state", 64'(bus.state_o), 64'd1);
    chk("t1_clear_en", 64'(bus.rdc_enable_o), 64'd0);
    tick();
    chk("t1_armed_state", 64'(bus.state_o), 64'd2);
    chk("t1_armed_en", 64'(bus.rdc_enable_o), 64'd1);
    tick();
    chk("t1_unbounded", 64'(bus.state_o), 64'd2);
    chk("t1_weights", bus.weights_o, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    chk("t1_stop", 64'(bus.state_o), 64'd0);

    // Window of 10 cycles with weight 3 = 0x05
    bus.weight_wr_i = 1'b1; bus.weight_idx_i = 3'd3; bus.weight_data_i = 8'h05;
    tick();
    bus.weight_wr_i = 1'b0;
    bus.start_i = 1'b1; bus.window_i = 32'd10;
    tick();
    bus.start_i = 1'b0;
    chk("t2_clear", 64'(bus.state_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t2_armed%0d", i), 64'(bus.state_o), 64'd2);
      chk($sformatf("t2_nodone%0d", i), 64'(bus.window_done_o), 64'd0);
    end
    chk("t2_w3", 64'(bus.weights_o[31:24]), 64'h05);
    tick();
    chk("t2_reclear", 64'(bus.state_o), 64'd1);
    chk("t2_done", 64'(bus.window_done_o), 64'd1);
    tick();
    chk("t2_rearm", 64'(bus.state_o), 64'd2);
    chk("t2_done_off", 64'(bus.window_done_o), 64'd0);

    // Interrupt, capture, hold, acknowledge
    bus.rdc_irq_i = 1'b1;
    tick();
    chk("t3_capture", 64'(bus.state_o), 64'd3);
    chk("t3_cap_en", 64'(bus.rdc_enable_o), 64'd1);
    chk("t3_count", 64'(bus.irq_count_o), 64'd1);
    bus.rdc_vector_i = 8'h08;
    tick();
    bus.rdc_irq_i = 1'b0; bus.rdc_vector_i = '0;
    chk("t3_hold", 64'(bus.state_o), 64'd4);
    chk("t3_irq", 64'(bus.irq_o), 64'd1);
    chk("t3_vec", 64'(bus.captured_vector_o), 64'h08);
    chk("t3_hold_en", 64'(bus.rdc_enable_o), 64'd0);
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    chk("t3_ack_clear", 64'(bus.state_o), 64'd1);
    chk("t3_irq_off", 64'(bus.irq_o), 64'd0);
    tick();
    chk("t3_rearm", 64'(bus.state_o), 64'd2);
    chk("t3_vec_held", 64'(bus.captured_vector_o), 64'h08);

    // Interrupt on the last window cycle beats expiry
    for (int i = 0; i < 9; i++) tick();
    chk("t4_still_armed", 64'(bus.state_o), 64'd2);
    bus.rdc_irq_i = 1'b1;
    tick();
    chk("t4_capture", 64'(bus.state_o), 64'd3);
    chk("t4_nodone", 64'(bus.window_done_o), 64'd0);
    bus.rdc_vector_i = 8'h01;
    tick();
    bus.rdc_irq_i = 1'b0; bus.rdc_vector_i = '0;
    chk("t4_hold", 64'(bus.state_o), 64'd4);
    chk("t4_vec", 64'(bus.captured_vector_o), 64'h01);
    chk("t4_count", 64'(bus.irq_count_o), 64'd2);
    bus.stop_i = 1'b1; bus.irq_ack_i = 1'b1;
    tick();
    bus.stop_i = 1'b0; bus.irq_ack_i = 1'b0;
    chk("t4_stop_wins", 64'(bus.state_o), 64'd0);
    chk("t4_irq_off", 64'(bus.irq_o), 64'd0);

    // Count saturation over 256 interrupt/ack rounds
    bus.window_i = 32'd0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) begin
      bus.rdc_irq_i = 1'b1;
      tick();
      bus.rdc_irq_i = 1'b0;
      tick();
      bus.irq_ack_i = 1'b1;
      tick();
      bus.irq_ack_i = 1'b0;
      tick();
    end
    chk("t5_sat_state", 64'(bus.state_o), 64'd2);
    chk("t5_sat", 64'(bus.irq_count_o), 64'd255);

    // Shadow write during CLEAR only lands on the following CLEAR
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("t6_clear", 64'(bus.state_o), 64'd1);
    bus.weight_wr_i = 1'b1; bus.weight_idx_i = 3'd3; bus.weight_data_i = 8'h01;
    tick();
    bus.weight_wr_i = 1'b0;
    chk("t6_w3_old", 64'(bus.weights_o[31:24]), 64'h05);
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    chk("t6_w3_new", 64'(bus.weights_o[31:24]), 64'h01);
    chk("t6_others", 64'({bus.weights_o[63:32], bus.weights_o[23:0]}), 64'hFF_FFFF_FFFF_FFFF);

    // Asynchronous reset while holding an interrupt
    bus.rdc_irq_i = 1'b1;
    tick();
    bus.rdc_vector_i = 8'h80;
    tick();
    bus.rdc_irq_i = 1'b0; bus.rdc_vector_i = '0;
    chk("t7_hold", 64'(bus.irq_o), 64'd1);
    chk("t7_vec", 64'(bus.captured_vector_o), 64'h80);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t7_rst_state", 64'(bus.state_o), 64'd0);
    chk("t7_rst_irq", 64'(bus.irq_o), 64'd0);
    chk("t7_rst_vec", 64'(bus.captured_vector_o), 64'd0);
    chk("t7_rst_count", 64'(bus.irq_count_o), 64'd0);
    chk("t7_rst_weights", bus.weights_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t7_rst_en", 64'(bus.rdc_enable_o), 64'd0);
    chk("t7_rst_wdone", 64'(bus.window_done_o), 64'd0);
    tick();
    chk("t7_rst_held", 64'(bus.state_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
